// File: rtl/seq_detect_pkg.sv
// Shared state type and default sizing for the serial pattern detector.
package seq_detect_pkg;

   localparam int DEFAULT_MAX_LEN = 8;
   localparam int DEFAULT_CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/seq_matcher.sv
// Serial history register with fill tracking; flags a match on the bit being shifted in.
module seq_matcher
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     shift_i,
   input  logic                     bit_i,
   input  logic [MAX_LEN-1:0]       pattern_i,
   input  logic [$clog2(MAX_LEN):0] len_i,
   output logic                     match_o
);

   localparam int LEN_W = $clog2(MAX_LEN) + 1;

   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] histNext;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fillNext;
   logic               patternHit;

   // Compare against the history as it will look after this bit lands, so the
   // registered detect pulse lines up with the edge that stores the bit.
   assign histNext = {hist_q[MAX_LEN-2:0], bit_i};
   assign fillNext = (fill_q >= len_i) ? len_i : fill_q + 1'b1;

   always_comb begin
      patternHit = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((i < int'(len_i)) && (histNext[i] != pattern_i[i])) begin
            patternHit = 1'b0;
         end
      end
   end

   assign match_o = shift_i && (fillNext >= len_i) && patternHit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (clear_i) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (shift_i) begin
         hist_q <= histNext;
         fill_q <= fillNext;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial sequence detector: config handshake, arm/abort control,
// saturating match counter and optional stop-after-N-detections.
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEFAULT_MAX_LEN,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [MAX_LEN-1:0]       cfg_pattern,
   input  logic [$clog2(MAX_LEN):0] cfg_len,
   input  logic [CNT_W-1:0]         cfg_target,
   output logic                     cfg_err,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     a,
   input  logic                     a_valid,
   output logic                     detected,
   output logic [CNT_W-1:0]         count,
   output logic                     busy,
   output logic                     done
);

   localparam int                 LEN_W     = $clog2(MAX_LEN) + 1;
   localparam logic [LEN_W-1:0]   MAX_LEN_V = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   state_t             state_q;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   target_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   countInc;
   logic               cfgErr_q;
   logic               detected_q;
   logic               cfgAccept;
   logic               cfgLegal;
   logic               armRun;
   logic               shiftEn;
   logic               match;

   assign cfgAccept = cfg_valid && (state_q != RUN);
   assign cfgLegal  = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
   assign armRun    = ((state_q == READY) || (state_q == DONE)) && start && !cfgAccept;
   assign shiftEn   = (state_q == RUN) && a_valid && !stop;
   assign countInc  = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

   seq_matcher #(
      .MAX_LEN (MAX_LEN)
   ) matcher (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (armRun),
      .shift_i   (shiftEn),
      .bit_i     (a),
      .pattern_i (pattern_q),
      .len_i     (len_q),
      .match_o   (match)
   );

   // A config offered while not running always takes priority over start;
   // a rejected config only raises the error pulse and leaves everything else alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pattern_q  <= '0;
         len_q      <= '0;
         target_q   <= '0;
         count_q    <= '0;
         cfgErr_q   <= 1'b0;
         detected_q <= 1'b0;
      end else begin
         cfgErr_q   <= 1'b0;
         detected_q <= 1'b0;
         if (cfgAccept) begin
            if (cfgLegal) begin
               pattern_q <= cfg_pattern;
               len_q     <= cfg_len;
               target_q  <= cfg_target;
               state_q   <= READY;
            end else begin
               cfgErr_q <= 1'b1;
            end
         end else begin
            case (state_q)
               READY, DONE: begin
                  if (start) begin
                     state_q <= RUN;
                     count_q <= '0;
                  end
               end
               RUN: begin
                  if (stop) begin
                     state_q <= READY;
                  end else if (match) begin
                     detected_q <= 1'b1;
                     count_q    <= countInc;
                     if ((target_q != '0) && (countInc == target_q)) begin
                        state_q <= DONE;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign cfg_ready = (state_q != RUN);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign cfg_err   = cfgErr_q;
   assign detected  = detected_q;
   assign count     = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios then random traffic, all checked
// against a bit-queue reference model of the detector's rules.
module tb_seq_detect_ctrl;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int LEN_W   = $clog2(MAX_LEN) + 1;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   localparam int M_IDLE  = 0;
   localparam int M_READY = 1;
   localparam int M_RUN   = 2;
   localparam int M_DONE  = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic [CNT_W-1:0]   cfg_target;
   logic               cfg_err;
   logic               start;
   logic               stop;
   logic               a;
   logic               a_valid;
   logic               detected;
   logic [CNT_W-1:0]   count;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;

   int mMode;
   int mPat;
   int mLen;
   int mTarget;
   int mCount;
   bit mBits[$];
   bit expDetected;
   bit expCfgErr;

   bit stream039 [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
   bit stream040 [7]  = '{1, 0, 1, 0, 1, 0, 1};

   always #5 clk = ~clk;

   seq_detect_ctrl #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .cfg_err     (cfg_err),
      .start       (start),
      .stop        (stop),
      .a           (a),
      .a_valid     (a_valid),
      .detected    (detected),
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   task automatic modelReset();
      mMode       = M_IDLE;
      mPat        = 0;
      mLen        = 0;
      mTarget     = 0;
      mCount      = 0;
      mBits.delete();
      expDetected = 1'b0;
      expCfgErr   = 1'b0;
   endtask

   // The model keeps every bit seen since arming and matches by reading the newest
   // mLen of them back against the pattern, newest bit against pattern bit 0.
   task automatic modelStep();
      bit hit;
      expDetected = 1'b0;
      expCfgErr   = 1'b0;
      if (cfg_valid && mMode != M_RUN) begin
         if (int'(cfg_len) == 0 || int'(cfg_len) > MAX_LEN) begin
            expCfgErr = 1'b1;
         end else begin
            mPat    = int'(cfg_pattern);
            mLen    = int'(cfg_len);
            mTarget = int'(cfg_target);
            mMode   = M_READY;
         end
      end else if ((mMode == M_READY || mMode == M_DONE) && start) begin
         mMode  = M_RUN;
         mCount = 0;
         mBits.delete();
      end else if (mMode == M_RUN && stop) begin
         mMode = M_READY;
      end else if (mMode == M_RUN && a_valid) begin
         mBits.push_back(a);
         if (mBits.size() > 32) void'(mBits.pop_front());
         hit = (mBits.size() >= mLen);
         for (int k = 0; k < mLen && hit; k++) begin
            if (mBits[mBits.size() - 1 - k] != mPat[k]) hit = 1'b0;
         end
         if (hit) begin
            expDetected = 1'b1;
            if (mCount < CNT_SAT) mCount++;
            if (mTarget != 0 && mCount == mTarget) mMode = M_DONE;
         end
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", name, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".detected"},  32'(detected),  32'(expDetected));
      checkValue({tag, ".cfg_err"},   32'(cfg_err),   32'(expCfgErr));
      checkValue({tag, ".count"},     32'(count),     32'(mCount));
      checkValue({tag, ".busy"},      32'(busy),      32'(mMode == M_RUN));
      checkValue({tag, ".done"},      32'(done),      32'(mMode == M_DONE));
      checkValue({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(mMode != M_RUN));
   endtask

   task automatic applyStimulus(input string tag, input logic cv,
                                input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                                input logic [CNT_W-1:0] tgt, input logic st, input logic sp,
                                input logic av, input logic ab);
      cfg_valid   = cv;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_target  = tgt;
      start       = st;
      stop        = sp;
      a_valid     = av;
      a           = ab;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(tag, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sendBit(input string tag, input logic b);
      applyStimulus(tag, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, b);
   endtask

   task automatic configure(input string tag, input logic [MAX_LEN-1:0] pat,
                            input logic [LEN_W-1:0] len, input logic [CNT_W-1:0] tgt);
      applyStimulus(tag, 1'b1, pat, len, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic arm(input string tag);
      applyStimulus(tag, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n       = 1'b0;
      cfg_valid   = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_target  = '0;
      start       = 1'b0;
      stop        = 1'b0;
      a           = 1'b0;
      a_valid     = 1'b0;
      modelReset();
      #2;
      checkOutput("reset_init");
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle("idle_after_reset");
      arm("idle_start_ignored");
      stop = 1'b0;

      $display("[TB] overlapping 6-bit pattern, unlimited target");
      configure("req039_cfg", 8'b0011_0011, 4'd6, 8'd0);
      arm("req039_arm");
      for (int i = 0; i < 10; i++) begin
         sendBit($sformatf("req039_bit%0d", i + 1), stream039[i]);
         if (i == 5) checkValue("req039_det_bit6", 32'(detected), 32'd1);
         if (i == 6) checkValue("req039_no_det_bit7", 32'(detected), 32'd0);
      end
      checkValue("req039_det_bit10", 32'(detected), 32'd1);
      checkValue("req039_count", 32'(count), 32'd2);
      checkValue("req039_busy", 32'(busy), 32'd1);

      $display("[TB] target of two detections ends in DONE");
      applyStimulus("req040_stop", 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      configure("req040_cfg", 8'b0000_1010, 4'd4, 8'd2);
      arm("req040_arm");
      for (int i = 0; i < 7; i++) begin
         sendBit($sformatf("req040_bit%0d", i + 1), stream040[i]);
         if (i == 3) checkValue("req040_det_bit4", 32'(detected), 32'd1);
         if (i == 5) checkValue("req040_done_bit6", 32'(done), 32'd1);
      end
      checkValue("req040_count_held", 32'(count), 32'd2);
      checkValue("req040_done_held", 32'(done), 32'd1);
      checkValue("req040_no_det_in_done", 32'(detected), 32'd0);

      $display("[TB] stop on the completing bit discards it");
      configure("req042_cfg", 8'b0000_1010, 4'd4, 8'd0);
      arm("req042_arm");
      sendBit("req042_bit1", 1'b1);
      sendBit("req042_bit2", 1'b0);
      sendBit("req042_bit3", 1'b1);
      applyStimulus("req042_stop_bit4", 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkValue("req042_no_det", 32'(detected), 32'd0);
      checkValue("req042_ready", 32'(busy | done), 32'd0);
      checkValue("req042_count", 32'(count), 32'd0);

      $display("[TB] oversize length rejected, config wins over start");
      configure("len9_cfg", 8'hFF, 4'd9, 8'd0);
      checkValue("len9_err", 32'(cfg_err), 32'd1);
      applyStimulus("cfg_and_start", 1'b1, 8'b0000_1010, 4'd4, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkValue("cfg_and_start_busy", 32'(busy), 32'd0);
      arm("old_cfg_arm");
      sendBit("old_cfg_bit1", 1'b1);
      sendBit("old_cfg_bit2", 1'b0);
      sendBit("old_cfg_bit3", 1'b1);
      sendBit("old_cfg_bit4", 1'b0);
      checkValue("old_cfg_det", 32'(detected), 32'd1);
      sendBit("old_cfg_bit5", 1'b1);

      $display("[TB] asynchronous reset while running");
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("req043_async_reset");
      checkValue("req043_cfg_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] zero length from IDLE");
      configure("req041_cfg_len0", 8'hAA, 4'd0, 8'd0);
      checkValue("req041_err", 32'(cfg_err), 32'd1);
      idleCycle("req041_err_clear");
      arm("req041_start");
      checkValue("req041_busy", 32'(busy), 32'd0);

      $display("[TB] counter saturation");
      configure("sat_cfg", 8'b0000_0001, 4'd1, 8'd0);
      arm("sat_arm");
      for (int i = 0; i < CNT_SAT + 5; i++) sendBit("sat_bit", 1'b1);
      checkValue("sat_count", 32'(count), 32'(CNT_SAT));
      checkValue("sat_det", 32'(detected), 32'd1);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         logic [LEN_W-1:0] rLen;
         rLen = ($urandom_range(3) == 0) ? LEN_W'($urandom_range(15))
                                         : LEN_W'($urandom_range(4, 1));
         applyStimulus("random", $urandom_range(15) == 0, MAX_LEN'($urandom),
                       rLen, CNT_W'($urandom_range(4)), $urandom_range(7) == 0,
                       $urandom_range(19) == 0, $urandom_range(3) != 0,
                       1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
